// File: rtl/gc_stream_receiver_if.sv
// Garbler output stream bundle: tag, cycle id, two indices, two data words.
// Driven by the garbler side, sampled by the evaluator-side receiver.
interface gc_stream_receiver_if #(
    parameter int S = 20,
    parameter int K = 128
);
    logic [2:0]   tag;
    logic [S-1:0] cid;
    logic [S-1:0] index0;
    logic [S-1:0] index1;
    logic [K-1:0] data0;
    logic [K-1:0] data1;

    modport master (
        output tag, cid, index0, index1, data0, data1
    );
    modport slave (
        input tag, cid, index0, index1, data0, data1
    );
endinterface

// File: rtl/gc_stream_receiver.sv
// Evaluator-side sink for the garbler stream: keys, labels, GT rows,
// output masks, cid tracking and sticky error flags.
module gc_stream_receiver #(
    parameter int S     = 20,
    parameter int K     = 128,
    parameter int D_LOG = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    gc_stream_receiver_if.slave st,
    input  logic [S-1:0]       gt_count,
    output logic               key_valid,
    output logic [K-1:0]       r_out,
    output logic [K-1:0]       aes_key,
    input  logic [D_LOG-1:0]   lbl_rd_addr,
    output logic [K-1:0]       lbl_rd_data,
    output logic               lbl_rd_valid,
    input  logic [D_LOG-1:0]   gt_rd_addr,
    output logic [2*K-1:0]     gt_rd_data,
    output logic               gt_rd_valid,
    output logic [2*K-1:0]     mask_out,
    output logic               cid_done,
    output logic [S-1:0]       exp_cid,
    output logic [3:0]         err
);
    localparam int DEPTH = 1 << D_LOG;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [S-1:0]     row_cnt;
    logic [DEPTH-1:0] lbl_vld;
    logic [DEPTH-1:0] gt_vld;
    logic [K-1:0]     lbl_mem [DEPTH];
    logic [2*K-1:0]   gt_mem  [DEPTH];

    logic t_keys, t_gt, t_mask, t_p0, t_p1, t_bad;
    logic run, acc;
    logic p0_ok, p1_ok, gt_ok, gt_match;
    logic lbl_we0, lbl_we1, gt_we;
    logic [S-1:0]     gt_i0;
    logic [D_LOG-1:0] a0, a1, ga;

    always_comb begin
        t_keys = st.tag == 3'b001;
        t_gt   = st.tag == 3'b010;
        t_mask = st.tag == 3'b011;
        t_bad  = st.tag == 3'b100;
        t_p0   = (st.tag == 3'b101) || (st.tag == 3'b111);
        t_p1   = (st.tag == 3'b110) || (st.tag == 3'b111);
    end

    assign run = (state == RUN) && !restart;
    assign acc = run && (t_gt || t_mask || t_p0 || t_p1);

    assign p0_ok = st.index0[S-1:D_LOG] == '0;
    assign p1_ok = st.index1[S-1:D_LOG] == '0;
    assign gt_ok = st.index0[S-1:D_LOG+1] == '0;

    // Rows must arrive as consecutive even/odd index pairs.
    assign gt_i0    = {row_cnt[S-2:0], 1'b0};
    assign gt_match = (st.index0 == gt_i0) &&
                      (st.index1 == {gt_i0[S-1:1], 1'b1});

    assign a0 = st.index0[D_LOG-1:0];
    assign a1 = st.index1[D_LOG-1:0];
    assign ga = st.index0[D_LOG:1];

    assign lbl_we0 = run && t_p0 && p0_ok;
    assign lbl_we1 = run && t_p1 && p1_ok;
    assign gt_we   = run && t_gt && gt_ok;

    // Port 1 written last so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (lbl_we0)
            lbl_mem[a0] <= st.data0;
        if (lbl_we1)
            lbl_mem[a1] <= st.data1;
        if (gt_we)
            gt_mem[ga] <= {st.data1, st.data0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            row_cnt      <= '0;
            lbl_vld      <= '0;
            gt_vld       <= '0;
            key_valid    <= 1'b0;
            r_out        <= '0;
            aes_key      <= '0;
            lbl_rd_data  <= '0;
            lbl_rd_valid <= 1'b0;
            gt_rd_data   <= '0;
            gt_rd_valid  <= 1'b0;
            mask_out     <= '0;
            cid_done     <= 1'b0;
            exp_cid      <= '0;
            err          <= '0;
        end else if (restart) begin
            state        <= IDLE;
            row_cnt      <= '0;
            lbl_vld      <= '0;
            gt_vld       <= '0;
            key_valid    <= 1'b0;
            r_out        <= '0;
            aes_key      <= '0;
            lbl_rd_data  <= '0;
            lbl_rd_valid <= 1'b0;
            gt_rd_data   <= '0;
            gt_rd_valid  <= 1'b0;
            mask_out     <= '0;
            cid_done     <= 1'b0;
            exp_cid      <= '0;
            err          <= '0;
        end else begin
            cid_done     <= 1'b0;
            lbl_rd_data  <= lbl_mem[lbl_rd_addr];
            lbl_rd_valid <= lbl_vld[lbl_rd_addr];
            gt_rd_data   <= gt_mem[gt_rd_addr];
            gt_rd_valid  <= gt_vld[gt_rd_addr];
            unique case (state)
                IDLE: begin
                    if (t_keys) begin
                        r_out     <= st.data0;
                        aes_key   <= st.data1;
                        key_valid <= 1'b1;
                        exp_cid   <= '0;
                        state     <= RUN;
                    end else if (st.tag != 3'b000) begin
                        err[0] <= 1'b1;
                    end
                end
                RUN: begin
                    if (t_keys || t_bad)
                        err[0] <= 1'b1;
                    if (acc && (st.cid != exp_cid))
                        err[1] <= 1'b1;
                    if ((t_p0 && !p0_ok) || (t_p1 && !p1_ok))
                        err[3] <= 1'b1;
                    if (lbl_we0)
                        lbl_vld[a0] <= 1'b1;
                    if (lbl_we1)
                        lbl_vld[a1] <= 1'b1;
                    if (t_gt) begin
                        if (gt_match)
                            row_cnt <= row_cnt + S'(1);
                        else
                            err[0] <= 1'b1;
                        if (gt_ok)
                            gt_vld[ga] <= 1'b1;
                        else
                            err[3] <= 1'b1;
                    end
                    if (t_mask) begin
                        mask_out <= {st.data0, st.data1};
                        cid_done <= 1'b1;
                        if (row_cnt != gt_count)
                            err[2] <= 1'b1;
                        lbl_vld <= '0;
                        gt_vld  <= '0;
                        row_cnt <= '0;
                        exp_cid <= exp_cid + S'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gc_stream_receiver.sv
// Randomized bench for gc_stream_receiver against a transaction-level
// model of the stream protocol, plus the directed protocol scenarios.
module tb_gc_stream_receiver;
    localparam int S = 20;
    localparam int K = 128;
    localparam int D_LOG = 8;
    localparam int DEPTH = 256;
    localparam int unsigned MSK = 32'h000F_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic restart;
    always #5 clk = ~clk;

    gc_stream_receiver_if #(.S(S), .K(K)) st ();

    logic [S-1:0]     gt_count;
    logic             key_valid;
    logic [K-1:0]     r_out, aes_key;
    logic [D_LOG-1:0] lbl_rd_addr, gt_rd_addr;
    logic [K-1:0]     lbl_rd_data;
    logic             lbl_rd_valid;
    logic [2*K-1:0]   gt_rd_data;
    logic             gt_rd_valid;
    logic [2*K-1:0]   mask_out;
    logic             cid_done;
    logic [S-1:0]     exp_cid;
    logic [3:0]       err;

    gc_stream_receiver #(.S(S), .K(K), .D_LOG(D_LOG)) dut (
        .clk(clk), .rst(rst), .restart(restart), .st(st),
        .gt_count(gt_count), .key_valid(key_valid),
        .r_out(r_out), .aes_key(aes_key),
        .lbl_rd_addr(lbl_rd_addr), .lbl_rd_data(lbl_rd_data),
        .lbl_rd_valid(lbl_rd_valid), .gt_rd_addr(gt_rd_addr),
        .gt_rd_data(gt_rd_data), .gt_rd_valid(gt_rd_valid),
        .mask_out(mask_out), .cid_done(cid_done),
        .exp_cid(exp_cid), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: protocol state kept as plain transaction-level data.
    bit             m_run, m_kv, m_done;
    logic [K-1:0]   m_r, m_k;
    logic [K-1:0]   m_lbl [DEPTH];
    bit             m_lv  [DEPTH];
    logic [2*K-1:0] m_gt  [DEPTH];
    bit             m_gv  [DEPTH];
    int unsigned    m_rows, m_cid;
    logic [2*K-1:0] m_mask;
    logic [3:0]     m_err;

    function automatic void m_reset();
        m_run = 0; m_kv = 0; m_done = 0;
        m_r = '0; m_k = '0; m_mask = '0; m_err = '0;
        m_rows = 0; m_cid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_lv[i] = 0;
            m_gv[i] = 0;
        end
    endfunction

    function automatic void m_apply(logic [2:0] t, int unsigned c,
        int unsigned i0, int unsigned i1, logic [K-1:0] d0,
        logic [K-1:0] d1, int unsigned gtc);
        int unsigned want;
        bit ok;
        m_done = 0;
        if (!m_run) begin
            if (t == 3'd1) begin
                m_r = d0; m_k = d1; m_kv = 1; m_cid = 0; m_run = 1;
            end else if (t != 3'd0) m_err[0] = 1;
            return;
        end
        if (t == 3'd0) return;
        if (t == 3'd1 || t == 3'd4) begin
            m_err[0] = 1;
            return;
        end
        if (c != m_cid) m_err[1] = 1;
        if (t == 3'd2) begin
            want = (2 * m_rows) & MSK;
            ok = (i0 == want) && (i1 == ((want + 1) & MSK));
            if (!ok) m_err[0] = 1;
            if (i0 / 2 < DEPTH) begin
                m_gt[i0/2] = {d1, d0};
                m_gv[i0/2] = 1;
            end else m_err[3] = 1;
            if (ok) m_rows++;
        end else if (t == 3'd3) begin
            m_mask = {d0, d1};
            m_done = 1;
            if (m_rows != gtc) m_err[2] = 1;
            for (int i = 0; i < DEPTH; i++) begin
                m_lv[i] = 0;
                m_gv[i] = 0;
            end
            m_rows = 0;
            m_cid = (m_cid + 1) & MSK;
        end else begin
            if (t != 3'd6) begin
                if (i0 < DEPTH) begin
                    m_lbl[i0] = d0; m_lv[i0] = 1;
                end else m_err[3] = 1;
            end
            if (t != 3'd5) begin
                if (i1 < DEPTH) begin
                    m_lbl[i1] = d1; m_lv[i1] = 1;
                end else m_err[3] = 1;
            end
        end
    endfunction

    task automatic cyc(logic [2:0] t, int unsigned c, int unsigned i0,
        int unsigned i1, logic [K-1:0] d0, logic [K-1:0] d1,
        int unsigned gtc, logic rs, int unsigned la, int unsigned ga);
        bit             e_lv, e_gv;
        logic [K-1:0]   e_ld;
        logic [2*K-1:0] e_gd;
        st.tag = t;
        st.cid = c[S-1:0];
        st.index0 = i0[S-1:0];
        st.index1 = i1[S-1:0];
        st.data0 = d0;
        st.data1 = d1;
        gt_count = gtc[S-1:0];
        restart = rs;
        lbl_rd_addr = la[D_LOG-1:0];
        gt_rd_addr = ga[D_LOG-1:0];
        if (rs) begin
            e_lv = 0; e_gv = 0; e_ld = '0; e_gd = '0;
            m_reset();
        end else begin
            e_lv = m_lv[la]; e_ld = m_lbl[la];
            e_gv = m_gv[ga]; e_gd = m_gt[ga];
            m_apply(t, c, i0, i1, d0, d1, gtc);
        end
        @(posedge clk);
        #1;
        chk("key_valid", key_valid, m_kv);
        chk("r_out", r_out, m_r);
        chk("aes_key", aes_key, m_k);
        chk("lbl_rd_valid", lbl_rd_valid, e_lv);
        if (rs || e_lv) chk("lbl_rd_data", lbl_rd_data, e_ld);
        chk("gt_rd_valid", gt_rd_valid, e_gv);
        if (rs || e_gv) chk("gt_rd_data", gt_rd_data, e_gd);
        chk("mask_out", mask_out, m_mask);
        chk("cid_done", cid_done, m_done);
        chk("exp_cid", exp_cid, m_cid);
        chk("err", err, m_err);
    endtask

    task automatic idle(int unsigned la, int unsigned ga);
        cyc(3'd0, 0, 0, 0, '0, '0, 0, 1'b0, la, ga);
    endtask

    task automatic do_rst();
        st.tag = 3'd0;
        restart = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_key_valid", key_valid, 0);
        chk("rst_keys", {r_out, aes_key}, 0);
        chk("rst_exp_cid", exp_cid, 0);
        chk("rst_err", err, 0);
        chk("rst_cid_done", cid_done, 0);
        chk("rst_mask", mask_out, 0);
        chk("rst_valids", {lbl_rd_valid, gt_rd_valid}, 0);
        chk("rst_rd_data", {lbl_rd_data, gt_rd_data[K-1:0]}, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [K-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [K-1:0] va, vb, key1, key2;
    logic [2:0]   t;
    int unsigned  c, i0, i1, gtc, pick;

    initial begin
        rst = 1'b0; restart = 1'b0;
        st.tag = '0; st.cid = '0; st.index0 = '0; st.index1 = '0;
        st.data0 = '0; st.data1 = '0;
        gt_count = '0; lbl_rd_addr = '0; gt_rd_addr = '0;
        m_reset();
        @(negedge clk);
        do_rst();
        idle(0, 0);

        key1 = 128'h1;
        key2 = {16{8'hAA}};
        cyc(3'd1, 0, 0, 0, key1, key2, 0, 1'b0, 0, 0);
        chk("dir_key_valid", key_valid, 1);
        chk("dir_r_out", r_out, key1);
        chk("dir_aes_key", aes_key, key2);

        va = rnd(); vb = rnd();
        cyc(3'd7, 0, 0, 1, va, vb, 0, 1'b0, 1, 0);
        idle(1, 0);
        chk("dir_lbl_b", lbl_rd_data, vb);
        chk("dir_lbl_b_valid", lbl_rd_valid, 1);

        for (int r = 0; r < 3; r++)
            cyc(3'd2, 0, 2*r, 2*r+1, rnd(), rnd(), 0, 1'b0, 0, 0);
        cyc(3'd3, 0, 0, 0, rnd(), rnd(), 3, 1'b0, 0, 0);
        chk("dir_cid_done", cid_done, 1);
        chk("dir_exp_cid", exp_cid, 1);
        chk("dir_err_clean", err, 0);
        idle(0, 0);
        chk("dir_gt_cleared", gt_rd_valid, 0);

        cyc(3'd2, 1, 0, 1, rnd(), rnd(), 0, 1'b0, 0, 0);
        cyc(3'd2, 1, 4, 5, rnd(), rnd(), 0, 1'b0, 0, 2);
        chk("dir_err_proto", err[0], 1);
        cyc(3'd3, 1, 0, 0, rnd(), rnd(), 3, 1'b0, 0, 2);
        chk("dir_err_gtcnt", err[2], 1);

        cyc(3'd0, 0, 0, 0, '0, '0, 0, 1'b1, 0, 0);
        cyc(3'd1, 0, 0, 0, key1, key2, 0, 1'b0, 0, 0);
        cyc(3'd5, 0, DEPTH, MSK, rnd(), rnd(), 0, 1'b0, 0, 0);
        chk("dir_err_range", err, 4'b1000);
        cyc(3'd5, 5, 3, MSK, rnd(), rnd(), 0, 1'b0, 0, 0);
        chk("dir_err_cid", err[1], 1);

        cyc(3'd0, 0, 0, 0, '0, '0, 0, 1'b1, 0, 0);
        cyc(3'd1, 0, 0, 0, key1, key2, 0, 1'b0, 0, 0);
        cyc(3'd1, 0, 0, 0, rnd(), rnd(), 0, 1'b0, 0, 0);
        chk("dir_keys_kept", {r_out, aes_key}, {key1, key2});
        chk("dir_rekey_err", err, 4'b0001);
        cyc(3'd2, 0, 0, 1, rnd(), rnd(), 0, 1'b0, 0, 0);
        do_rst();

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) do_rst();
            pick = $urandom_range(0, 99);
            c = ($urandom_range(0, 19) == 0) ? ($urandom & MSK) : m_cid;
            i0 = $urandom_range(0, 15);
            i1 = $urandom_range(0, 15);
            gtc = 0;
            if (!m_run) begin
                t = (pick < 70) ? 3'd1 : 3'($urandom_range(0, 7));
            end else if (pick < 35) begin
                t = 3'($urandom_range(5, 7));
                if ($urandom_range(0, 19) == 0) i0 = DEPTH + $urandom_range(0, 40);
                if ($urandom_range(0, 19) == 0) i1 = DEPTH + $urandom_range(0, 40);
            end else if (pick < 65) begin
                t = 3'd2;
                i0 = 2 * m_rows;
                i1 = i0 + 1;
                if ($urandom_range(0, 9) == 0) begin
                    i0 = $urandom_range(0, 20);
                    i1 = $urandom_range(0, 20);
                end
            end else if (pick < 75) begin
                t = 3'd3;
                gtc = ($urandom_range(0, 4) == 0) ? m_rows + 1 : m_rows;
            end else if (pick < 90) begin
                t = 3'd0;
            end else begin
                t = 3'($urandom_range(0, 7));
            end
            cyc(t, c, i0, i1, rnd(), rnd(), gtc,
                $urandom_range(0, 99) < 2, $urandom_range(0, 15),
                $urandom_range(0, 9));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
